wb_ram_bank_if: RTL
===================

# wb_ram_bank_if

Parametrised single-clock Wishbone slave bridging one Wishbone bus to `NUM_BANKS` synchronous RAM banks (IRAM, DRAM and further scratch banks) behind a shared address/data/byte-enable bus. It generalises the fixed two-bank bridge in three ways:
- configurable bank count, depth and RAM read latency;
- byte-lane writes via `wb_sel_i`;
- an error response for unmapped addresses.

It sits between the core's Wishbone crossbar and the `soc_sram_dualport` port-B instances.

## Interface
- `NUM_BANKS`, default 2: number of RAM banks, 1..8; bank 0 = IRAM, bank 1 = DRAM.
- `RAM_ADDR_WIDTH`, default 12: word address width per bank.
- `RAM_DATA_WIDTH`, default 32: data width; must be 32.
- `READ_LATENCY`, default 1: RAM clock-to-data latency in cycles, 1..4.
- `clk_i` in 1: clock; one clock for bus and RAMs.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_wr_en_i` in 1: 1 = write.
- `wb_addr_i` in 32: byte address.
- `wb_wdata_i` in 32: write data.
- `wb_sel_i` in 4: byte lane select.
- `wb_rdata_o` out 32: read data; valid only while `wb_ack_o`=1, else 0.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `wb_err_o` out 1: one-cycle error, for unmapped addresses.
- `ram_addr_o` out RAM_ADDR_WIDTH: shared word address.
- `ram_data_o` out 32: shared write data.
- `ram_be_o` out 4: shared byte enables.
- `ram_we_o` out NUM_BANKS: per-bank write enable.
- `ram_rdata_i` in NUM_BANKS*32: bank k read data at bits [32k+31:32k].

## Operation
- **Decode.** BSW = max(1, clog2(NUM_BANKS)).
  - word = `wb_addr_i[RAM_ADDR_WIDTH+1:2]`
  - bank = `wb_addr_i[RAM_ADDR_WIDTH+BSW+1:RAM_ADDR_WIDTH+2]`
  - Address bits [1:0] are ignored.
  - Address is unmapped if bank >= NUM_BANKS, or any bit above the bank field is 1.
- **FSM.** States IDLE, WRITE, READ_WAIT, RESP.
  - **IDLE:** on `wb_cyc_i & wb_stb_i`, register word, bank, `wb_wdata_i`, `wb_sel_i` and `wb_wr_en_i`.
    - Unmapped → RESP with err.
    - Mapped write → WRITE.
    - Mapped read → READ_WAIT; latency counter is loaded with READ_LATENCY.
  - **WRITE:** `ram_we_o[bank]`=1 for exactly this cycle; `ram_be_o` = registered sel; `wb_ack_o`=1 this cycle; next state IDLE.
  - **READ_WAIT:** `ram_addr_o` holds the word and all `ram_we_o`=0. The counter decrements each cycle; when it reaches 1, next state is RESP with ack.
  - **RESP:**
    - Read: `wb_ack_o`=1 and `wb_rdata_o` = `ram_rdata_i` slice of the registered bank.
    - Error: `wb_err_o`=1 and `wb_rdata_o`=0.
    - Next state IDLE.
- **Overlap.** A new request is accepted only in IDLE. A strobe still high in the cycle after ack/err is treated as a new transaction.
- **Abort.** `wb_cyc_i`=0 during READ_WAIT → IDLE next cycle, no ack. A write in WRITE cannot be aborted.
- **Sel.** `wb_sel_i`=0000 on a write still pulses `ram_we_o` with `ram_be_o`=0000 and acks; the RAM contents stay unchanged.
- **Idle outputs.** `ram_addr_o`, `ram_data_o` and `ram_be_o` hold their last registered values; `ram_we_o` is always 0 outside WRITE.
- `wb_ack_o` and `wb_err_o` are never high together.

## Timing
- **Reset.** Asynchronous. While `rst_ni`=0:
  - FSM = IDLE.
  - `wb_ack_o`, `wb_err_o`, `ram_we_o`, `ram_be_o` = 0.
  - `ram_addr_o`, `ram_data_o`, `wb_rdata_o` = 0.
  - Reset mid-transaction drops it silently; no ack after release.
- **Request sampled in cycle N:**
  - Write: `ram_we_o` and ack both in N+1; next accept at N+2.
  - Read: address valid from N+1; ack in N+1+READ_LATENCY; next accept at N+2+READ_LATENCY.
  - Error: `wb_err_o` in N+1.
- **Throughput.** Sustained:
  - writes: 1 per 2 cycles;
  - reads: 1 per READ_LATENCY+2 cycles.
- All outputs are registered except `wb_rdata_o`. `wb_rdata_o` is a mux of `ram_rdata_i` gated by the registered RESP state and registered bank.

## Test plan
- **Write/read IRAM.** NUM_BANKS=2, READ_LATENCY=1. Write 0xDEADBEEF to 0x0000_0010, sel=1111 → `ram_we_o`=01, `ram_addr_o`=4, ack in N+1. Then read 0x10 → ack in N+2, rdata=0xDEADBEEF.
- **Bank select / byte lanes.** Write 0x11223344 to DRAM 0x0000_4008 (bank 1, word 2). Then write 0xAABBCCDD with sel=0010. Read back 0x4008 → 0x1122CC44; IRAM word 2 unchanged.
- **Unmapped.** NUM_BANKS=3:
  - read 0x0000_C000 (bank 3) → `wb_err_o` in N+1, `wb_ack_o`=0, rdata=0, no `ram_we_o`;
  - write 0x0001_0000 (high bit set) → err, no write.
- **Latency.** READ_LATENCY=3: read → ack exactly at N+4. With `wb_stb_i` held high across a 4-read burst, ack pulses are 5 cycles apart and each returns the correct data.
- **Abort and reset.**
  - Drop `wb_cyc_i` in N+2 of a READ_LATENCY=3 read → no ack; next request is accepted at N+3.
  - Assert `rst_ni`=0 in the WRITE cycle → `ram_we_o` drops immediately, and no ack follows after release.

Source files
------------

// File: rtl/wb_ram_bank_if_if.sv
// Bus bundle between a Wishbone master, the RAM bank bridge and the RAM
// bank port-B instances (shared address/data/byte-enable, per-bank we).
interface wb_ram_bank_if_if #(
    parameter int NUM_BANKS      = 2,
    parameter int RAM_ADDR_WIDTH = 12
);
    logic                          wb_cyc_i;
    logic                          wb_stb_i;
    logic                          wb_wr_en_i;
    logic [31:0]                   wb_addr_i;
    logic [31:0]                   wb_wdata_i;
    logic [3:0]                    wb_sel_i;
    logic [31:0]                   wb_rdata_o;
    logic                          wb_ack_o;
    logic                          wb_err_o;
    logic [RAM_ADDR_WIDTH-1:0]     ram_addr_o;
    logic [31:0]                   ram_data_o;
    logic [3:0]                    ram_be_o;
    logic [NUM_BANKS-1:0]          ram_we_o;
    logic [NUM_BANKS*32-1:0]       ram_rdata_i;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_wr_en_i, wb_addr_i, wb_wdata_i, wb_sel_i,
        input  ram_rdata_i,
        output wb_rdata_o, wb_ack_o, wb_err_o,
        output ram_addr_o, ram_data_o, ram_be_o, ram_we_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_wr_en_i, wb_addr_i, wb_wdata_i, wb_sel_i,
        input  wb_rdata_o, wb_ack_o, wb_err_o
    );

    modport ram (
        input  ram_addr_o, ram_data_o, ram_be_o, ram_we_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/wb_ram_bank_if.sv
// Wishbone slave bridging one bus onto NUM_BANKS synchronous RAM banks with
// byte-lane writes, configurable read latency and error response for holes.
module wb_ram_bank_if #(
    parameter int NUM_BANKS      = 2,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int READ_LATENCY   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    wb_ram_bank_if_if.slave      bus
);

    localparam int BSW      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BANK_LSB = RAM_ADDR_WIDTH + 2;
    localparam int HI_LSB   = BANK_LSB + BSW;
    localparam int NSLOT    = 1 << BSW;
    localparam int DW       = RAM_DATA_WIDTH;
    localparam logic [BSW:0] NB_L = (BSW + 1)'(NUM_BANKS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_READ_WAIT = 2'd2,
        S_RESP      = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [BSW-1:0]            bank_q,  bank_d;
    logic [31:0]               data_q,  data_d;
    logic [3:0]                be_q,    be_d;
    logic [NUM_BANKS-1:0]      we_q,    we_d;
    logic                      ack_q,   ack_d;
    logic                      err_q,   err_d;
    logic [2:0]                cnt_q,   cnt_d;

    logic                      req;
    logic                      accept;
    logic                      hi_set;
    logic                      bank_oob;
    logic                      unmapped;
    logic [RAM_ADDR_WIDTH-1:0] req_word;
    logic [BSW-1:0]            req_bank;
    logic [NUM_BANKS-1:0]      bank_hit;
    logic [DW-1:0]             bank_rdata [NSLOT];
    logic                      unused_addr_bits;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign req              = bus.wb_cyc_i & bus.wb_stb_i;
    assign accept           = (state_q == S_IDLE) & req;
    assign req_word         = bus.wb_addr_i[BANK_LSB-1:2];
    assign req_bank         = bus.wb_addr_i[HI_LSB-1:BANK_LSB];
    assign unused_addr_bits = ^bus.wb_addr_i[1:0];

    generate
        if (HI_LSB < 32) begin : g_hi
            assign hi_set = |bus.wb_addr_i[31:HI_LSB];
        end else begin : g_no_hi
            assign hi_set = 1'b0;
        end
    endgenerate

    assign bank_oob = ({1'b0, req_bank} >= NB_L);
    assign unmapped = hi_set | bank_oob;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_hit
            assign bank_hit[gi] = (req_bank == BSW'(gi));
        end
    endgenerate

    // Unpopulated slots of the power-of-two mux read as zero.
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_rslot
            if (gi < NUM_BANKS) begin : g_bank
                assign bank_rdata[gi] = bus.ram_rdata_i[gi*DW +: DW];
            end else begin : g_hole
                assign bank_rdata[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register (all outputs except read data are registered here)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            bank_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            we_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            data_q  <= data_d;
            be_q    <= be_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (unmapped)             state_d = S_RESP;
                    else if (bus.wb_wr_en_i)  state_d = S_WRITE;
                    else                      state_d = S_READ_WAIT;
                end
            end
            S_WRITE:     state_d = S_IDLE;
            S_READ_WAIT: begin
                if (!bus.wb_cyc_i)        state_d = S_IDLE;
                else if (cnt_q == 3'd1)   state_d = S_RESP;
            end
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        bank_d = bank_q;
        data_d = data_q;
        be_d   = be_q;
        cnt_d  = cnt_q;
        we_d   = '0;
        ack_d  = 1'b0;
        err_d  = 1'b0;

        if (accept) begin
            addr_d = req_word;
            bank_d = req_bank;
            data_d = bus.wb_wdata_i;
            be_d   = bus.wb_sel_i;
            cnt_d  = 3'(READ_LATENCY);
            if (unmapped) begin
                err_d = 1'b1;
            end else if (bus.wb_wr_en_i) begin
                we_d  = bank_hit;
                ack_d = 1'b1;
            end
        end

        // Dropping cyc aborts the read; the ack is only raised if cyc survives.
        if (state_q == S_READ_WAIT) begin
            cnt_d = cnt_q - 3'd1;
            if (bus.wb_cyc_i && (cnt_q == 3'd1)) ack_d = 1'b1;
        end
    end

    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_err_o   = err_q;
    assign bus.ram_addr_o = addr_q;
    assign bus.ram_data_o = data_q;
    assign bus.ram_be_o   = be_q;
    assign bus.ram_we_o   = we_q;
    assign bus.wb_rdata_o = ((state_q == S_RESP) && ack_q) ? bank_rdata[bank_q] : '0;

endmodule
